// File: rtl/divider64_if.sv
// Handshake and operand/result bundle between the M-extension control and divider64.
// Control (master) drives start, is_signed and the operands; the divider (slave) returns busy/done and results.
// Operands only need to be valid on the cycle start is accepted.
interface divider64_if #(
  parameter int WIDTH = 64
) ();
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/divider64.sv
// Iterative radix-2 restoring divider, RV64M DIV/DIVU/REM/REMU semantics (quotient and remainder together).
// Latency: WIDTH+2 clocks from start to done (2 clocks for b=0 / signed overflow when DIVIDER64_EARLY_OUT_EN is defined).
// Backpressure: start is taken only while idle; start during busy is ignored, results hold until the next done.
module divider64 #(
  parameter int WIDTH = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  divider64_if.slave  dif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q;        // original dividend, needed for the b=0 remainder
  logic [WIDTH-1:0] divisor;    // |b| (or b when unsigned)
  logic [WIDTH-1:0] dvd;        // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] rem;        // partial remainder
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;
  logic             ovf;
  logic             done_q;
  logic [WIDTH-1:0] quo_out;
  logic [WIDTH-1:0] rem_out;

  // operand classification at the accept point
  logic a_neg_in, b_neg_in, b_zero_in, ovf_in;
  assign a_neg_in  = dif.is_signed & dif.a[WIDTH-1];
  assign b_neg_in  = dif.is_signed & dif.b[WIDTH-1];
  assign b_zero_in = (dif.b == '0);
  assign ovf_in    = dif.is_signed && (dif.a == MIN_NEG) && (dif.b == '1);

  // Trial subtraction. The shifted partial remainder is WIDTH+1 bits; its top bit is rem[WIDTH-1].
  // If that bit is set the shifted value already exceeds any divisor, so the subtraction cannot borrow.
  // Otherwise the carry-out of the WIDTH+1 bit add (low bits + ~divisor + 1) decides.
  logic [WIDTH-1:0] rem_sh_lo;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  assign rem_sh_lo = {rem[WIDTH-2:0], dvd[WIDTH-1]};
  assign trial     = {1'b0, rem_sh_lo} + {1'b0, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
  assign no_borrow = rem[WIDTH-1] | trial[WIDTH];

  // sign fixup followed by the special-case overrides
  logic [WIDTH-1:0] q_fin, r_fin;
  always_comb begin
    q_fin = q_neg ? -dvd : dvd;
    r_fin = r_neg ? -rem : rem;
    if (div_zero) begin
      q_fin = '1;
      r_fin = a_q;
    end else if (ovf) begin
      q_fin = a_q;
      r_fin = '0;
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dif.start) begin
`ifdef DIVIDER64_EARLY_OUT_EN
          state_nxt = (b_zero_in || ovf_in) ? FINISH : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (cnt == CW'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: operand capture, one restoring step per CALC cycle, result registration in FINISH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      divisor  <= '0;
      dvd      <= '0;
      rem      <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      quo_out  <= '0;
      rem_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dif.start) begin
            a_q      <= dif.a;
            divisor  <= b_neg_in ? -dif.b : dif.b;
            dvd      <= a_neg_in ? -dif.a : dif.a;
            rem      <= '0;
            cnt      <= CW'(WIDTH);
            q_neg    <= a_neg_in ^ b_neg_in;
            r_neg    <= a_neg_in;
            div_zero <= b_zero_in;
            ovf      <= ovf_in;
          end
        end
        CALC: begin
          rem <= no_borrow ? trial[WIDTH-1:0] : rem_sh_lo;
          dvd <= {dvd[WIDTH-2:0], no_borrow};
          cnt <= cnt - CW'(1);
        end
        FINISH: begin
          quo_out <= q_fin;
          rem_out <= r_fin;
        end
        default: ;
      endcase
    end
  end

  // done pulses in the cycle after the FINISH edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done_q <= 1'b0;
    else          done_q <= (state == FINISH);
  end

  assign dif.busy      = (state != IDLE);
  assign dif.done      = done_q;
  assign dif.quotient  = quo_out;
  assign dif.remainder = rem_out;

endmodule

// File: tb/tb_divider64.sv
// Scoreboard bench for divider64: the driver queues expected results, the monitor checks each done.
// Directed vectors cover unsigned/signed division, divide-by-zero, signed overflow, start-while-busy,
// back-to-back issue and reset in mid-operation.
module tb_divider64;

`ifdef DIVIDER64_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = 66;
`endif
  localparam int NORMAL_LAT = 66;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
    int          iss;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  divider64_if #(.WIDTH(64)) dif ();

  divider64 #(.WIDTH(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dif     (dif)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  // drive one accepted start; called right after a negedge while the divider is idle
  task automatic issue(input logic [63:0] av, input logic [63:0] bv, input logic sg,
                       input logic [63:0] eq, input logic [63:0] er, input int lat);
    exp_t e;
    dif.a = av;
    dif.b = bv;
    dif.is_signed = sg;
    dif.start = 1'b1;
    e.q = eq;
    e.r = er;
    e.lat = lat;
    e.iss = cyc;
    sb.push_back(e);
    @(negedge clk);
    dif.start = 1'b0;
    dif.a = 64'hDEAD_BEEF_DEAD_BEEF;
    dif.b = 64'h5;
    dif.is_signed = ~sg;
    check("busy_after_start", {63'b0, dif.busy}, 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || dif.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk_cnt++;
      $display("FAIL wait_idle: still busy=%0d with %0d results outstanding after 200 cycles", dif.busy, sb.size());
    end
    @(negedge clk);
  endtask

  // monitor: compare every done against the head of the scoreboard
  initial begin : monitor
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_prev) check("done_one_cycle", {63'b0, dif.done}, 64'd0);
      if (dif.done) begin
        if (sb.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_done: done=1 with nothing outstanding (q=%h r=%h) cycle %0d",
                   dif.quotient, dif.remainder, cyc);
        end else begin
          e = sb.pop_front();
          check("quotient", dif.quotient, e.q);
          check("remainder", dif.remainder, e.r);
          check("latency", 64'(cyc - e.iss), 64'(e.lat));
        end
      end
      done_prev = dif.done;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int n;
    int seen;
    reset_n = 1'b0;
    dif.start = 1'b0;
    dif.is_signed = 1'b0;
    dif.a = '0;
    dif.b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'b0, dif.busy}, 64'd0);
    check("reset_done", {63'b0, dif.done}, 64'd0);
    check("reset_quotient", dif.quotient, 64'd0);
    check("reset_remainder", dif.remainder, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, NORMAL_LAT);
    wait_idle();
    issue(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, NORMAL_LAT);
    wait_idle();
    issue(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, NORMAL_LAT);
    wait_idle();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'd1, 64'd1, NORMAL_LAT);
    wait_idle();

    // start while busy is ignored; a start in the done cycle is accepted
    issue(64'd50, 64'd3, 1'b0, 64'd16, 64'd2, NORMAL_LAT);
    repeat (8) @(negedge clk);
    dif.a = 64'd9;
    dif.b = 64'd9;
    dif.is_signed = 1'b0;
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    n = 0;
    while (!dif.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!dif.done) begin
      chk_cnt++;
      $display("FAIL b2b_wait: done=0 after 100 cycles, required done=1");
    end
    issue(64'd9, 64'd9, 1'b0, 64'd1, 64'd0, NORMAL_LAT);
    wait_idle();

    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 64'd0, SPECIAL_LAT);
    wait_idle();
    issue(64'h1234, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, SPECIAL_LAT);
    wait_idle();

    // reset in the middle of a divide: outputs clear at once, no done follows
    dif.a = 64'd1000;
    dif.b = 64'd3;
    dif.is_signed = 1'b0;
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (29) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_busy", {63'b0, dif.busy}, 64'd0);
    check("midreset_done", {63'b0, dif.done}, 64'd0);
    check("midreset_quotient", dif.quotient, 64'd0);
    check("midreset_remainder", dif.remainder, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (dif.done) seen++;
    end
    check("no_done_after_reset", 64'(seen), 64'd0);

    issue(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, NORMAL_LAT);
    wait_idle();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
